// File: rtl/ot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ot_pkg                                                               |
// | Shared constants, FSM encoding and saturating add for the output     |
// | tile SRAM controller.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ot_pkg;

   localparam int WORDS = 3136;
   localparam int DW    = 26;
   localparam int AW    = $clog2(WORDS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACC_RD = 3'd1,
      ST_ACC_WR = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // One extra sign bit catches overflow; clamp toward the overflowing sign.
   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {a[DW-1], a} + {b[DW-1], b};
      if (s[DW] != s[DW-1])
         return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      return s[DW-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ot_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ot_skid_buf                                                          |
// | Two-entry valid/ready FIFO with occupancy count for upstream gating. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ot_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign w_pop  = out_valid & out_ready;
   assign w_push = in_valid & ((r_count != 2'd2) | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr];
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/ot_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ot_accum_ctrl                                                        |
// | Output-tile SRAM sequencer: saturating psum accumulation, then an    |
// | in-order valid/ready drain of every word to writeback.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ot_accum_ctrl
   import ot_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          psum_valid,
   output logic          psum_ready,
   input  logic [AW-1:0] psum_addr,
   input  logic [DW-1:0] psum_data,
   input  logic          psum_first,
   input  logic          drain_start,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          err_addr,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout,
   output logic          sram_final_flag
);

   localparam logic [AW:0] c_words = (AW+1)'(WORDS);

   state_t        r_state;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic [AW:0]   r_rp;
   logic          r_inflight;
   logic          r_inflight_last;
   logic          r_err;
   logic          r_final;

   logic          w_sk_valid;
   logic [DW:0]   w_sk_data;
   logic [1:0]    w_sk_count;
   logic          w_pop;
   logic          w_acc;
   logic          w_in_range;
   logic [2:0]    w_credit;
   logic          w_issue;

   assign psum_ready = rst_n && (r_state == ST_IDLE) && !drain_start;
   assign w_acc      = psum_valid && psum_ready;
   assign w_in_range = ({1'b0, psum_addr} < c_words);
   assign w_pop      = w_sk_valid && out_ready;

   // A word popped this cycle frees its slot in time for the read issued now.
   assign w_credit = 3'(w_sk_count) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue  = (r_state == ST_DRAIN) && (r_rp < c_words) && (w_credit < 3'd2);

   always_comb begin
      sram_we   = 1'b0;
      sram_addr = '0;
      sram_din  = '0;
      if (rst_n) begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc && w_in_range) begin
                  sram_addr = psum_addr;
                  if (psum_first) begin
                     sram_we  = 1'b1;
                     sram_din = psum_data;
                  end
               end
            end
            ST_ACC_RD: begin
               sram_we   = 1'b1;
               sram_addr = r_addr;
               sram_din  = sat_add(sram_dout, r_data);
            end
            ST_DRAIN: begin
               if (w_issue)
                  sram_addr = r_rp[AW-1:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_data          <= '0;
         r_rp            <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_err           <= 1'b0;
         r_final         <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_rp == c_words - 1'b1);
         case (r_state)
            ST_IDLE: begin
               if (drain_start) begin
                  r_state <= ST_DRAIN;
                  r_rp    <= '0;
                  r_final <= 1'b1;
               end else if (w_acc) begin
                  if (!w_in_range) begin
                     r_err <= 1'b1;
                  end else if (!psum_first) begin
                     r_addr  <= psum_addr;
                     r_data  <= psum_data;
                     r_state <= ST_ACC_RD;
                  end
               end
            end
            ST_ACC_RD: r_state <= ST_ACC_WR;
            ST_ACC_WR: r_state <= ST_IDLE;
            ST_DRAIN: begin
               if (w_issue)
                  r_rp <= r_rp + 1'b1;
               if ((r_rp == c_words) && !r_inflight && (w_sk_count == 2'd0)) begin
                  r_state <= ST_DONE;
                  r_final <= 1'b0;
               end
            end
            ST_DONE:   r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   ot_skid_buf #(
      .W(DW + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (r_inflight),
      .in_data   ({r_inflight_last, sram_dout}),
      .out_valid (w_sk_valid),
      .out_ready (out_ready),
      .out_data  (w_sk_data),
      .count     (w_sk_count)
   );

   assign out_valid       = w_sk_valid;
   assign out_data        = w_sk_data[DW-1:0];
   assign out_last        = w_sk_valid && w_sk_data[DW];
   assign busy            = (r_state != ST_IDLE) || (w_sk_count != 2'd0);
   assign err_addr        = r_err;
   assign sram_final_flag = r_final;

endmodule
`default_nettype wire

// File: tb/tb_ot_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ot_accum_ctrl                                                     |
// | Directed bench with a word-array model of the tile contents.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ot_accum_ctrl;
   import ot_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          psum_valid = 1'b0;
   logic          psum_ready;
   logic [AW-1:0] psum_addr = '0;
   logic [DW-1:0] psum_data = '0;
   logic          psum_first = 1'b0;
   logic          drain_start = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          err_addr;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout = '0;
   logic          sram_final_flag;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0]        mem [WORDS];
   logic signed [DW-1:0] exp_mem [WORDS];
   logic signed [DW-1:0] got_mem [WORDS];
   int  exp_idx = 0;
   int  gaps = 0;
   bit  full_rate_mode = 1'b0;
   bit  rnd_mode = 1'b0;
   bit  stall_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always #5 clk = ~clk;

   ot_accum_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .psum_valid      (psum_valid),
      .psum_ready      (psum_ready),
      .psum_addr       (psum_addr),
      .psum_data       (psum_data),
      .psum_first      (psum_first),
      .drain_start     (drain_start),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_last        (out_last),
      .busy            (busy),
      .err_addr        (err_addr),
      .sram_we         (sram_we),
      .sram_addr       (sram_addr),
      .sram_din        (sram_din),
      .sram_dout       (sram_dout),
      .sram_final_flag (sram_final_flag)
   );

   // Synchronous single-port SRAM, read data one cycle after the address
   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
   end

   always @(posedge clk) begin
      #1;
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic signed [DW-1:0] msat(input longint s);
      if (s > 33554431)  return 26'sd33554431;
      if (s < -33554432) return -26'sd33554432;
      return DW'(s);
   endfunction

   task automatic send(input int a, input longint d, input bit f);
      int t = 0;
      psum_valid = 1'b1;
      psum_addr  = AW'(a);
      psum_data  = DW'(d);
      psum_first = f;
      @(negedge clk);
      while (!psum_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!psum_ready) begin
         chk("psum_ready_timeout", psum_ready, 1);
      end else if (a >= WORDS) begin
         chk("oor_no_we", sram_we, 0);
      end else if (f) begin
         chk("first_we", sram_we, 1);
         chk("first_addr", sram_addr, a);
         chk("first_din", $signed(sram_din), d);
         exp_mem[a] = DW'(d);
      end else begin
         chk("acc_rd_we", sram_we, 0);
         chk("acc_rd_addr", sram_addr, a);
         exp_mem[a] = msat(longint'(exp_mem[a]) + d);
      end
      @(posedge clk);
      #1 psum_valid = 1'b0;
   endtask

   // Per-cycle drain checker against the model contents
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev) begin
            chk("stall_valid_held", out_valid, 1);
            chk("stall_data_stable", out_data, prev_data);
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && out_ready) begin
            if (exp_idx < WORDS) begin
               chk("drain_data", $signed(out_data), exp_mem[exp_idx]);
               chk("drain_last", out_last, (exp_idx == WORDS - 1) ? 1 : 0);
               got_mem[exp_idx] = out_data;
            end else begin
               chk("drain_overrun_idx", exp_idx, WORDS - 1);
            end
            exp_idx++;
         end
         if (full_rate_mode && sram_final_flag && exp_idx > 0 && exp_idx < WORDS && !out_valid)
            gaps++;
         if (sram_final_flag && sram_we)
            chk("no_write_in_drain", sram_we, 0);
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      int t;
      int lat;
      for (int i = 0; i < WORDS; i++) begin
         mem[i]     <= DW'(i * 913 - 1400000);
         exp_mem[i] = DW'(i * 913 - 1400000);
         got_mem[i] = '0;
      end

      repeat (2) @(negedge clk);
      chk("rst_psum_ready", psum_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_addr", err_addr, 0);
      chk("rst_sram_we", sram_we, 0);
      chk("rst_final_flag", sram_final_flag, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", psum_ready, 1);
      chk("post_rst_busy", busy, 0);

      // Overwrite then accumulate; ready drops for exactly two cycles
      send(5, 100, 1'b1);
      send(5, -30, 1'b0);
      t = 0;
      @(negedge clk);
      while (!psum_ready && t < 10) begin
         t++;
         @(negedge clk);
      end
      chk("acc_ready_low_cycles", t, 2);

      send(7, 33554432 - 10, 1'b1);
      send(7, 50, 1'b0);
      send(8, -33554432, 1'b1);
      send(8, -1, 1'b0);

      send(0, 0, 1'b1);
      send(0, 1, 1'b0);
      send(0, 1, 1'b0);
      send(0, 1, 1'b0);

      chk("err_before_oor", err_addr, 0);
      send(3136, 77, 1'b0);
      @(negedge clk);
      chk("err_after_oor", err_addr, 1);
      send(4095, 12, 1'b1);
      send(9, 5, 1'b0);
      send(10, -123456, 1'b1);
      repeat (3) @(negedge clk);
      chk("err_sticky", err_addr, 1);

      // Full-rate drain; a concurrent psum must lose to drain_start
      @(posedge clk);
      #1;
      exp_idx = 0;
      gaps = 0;
      full_rate_mode = 1'b1;
      psum_valid = 1'b1; psum_addr = AW'(1); psum_data = DW'(999); psum_first = 1'b1;
      drain_start = 1'b1;
      @(negedge clk);
      chk("drain_wins_ready", psum_ready, 0);
      chk("drain_wins_we", sram_we, 0);
      @(posedge clk);
      #1 drain_start = 1'b0; psum_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      chk("drain_latency_le3", (lat <= 3) ? 1 : 0, 1);
      t = 0;
      while (exp_idx < WORDS && t < 5000) begin
         chk("final_flag_high", sram_final_flag, 1);
         @(negedge clk);
         t++;
      end
      chk("drain_word_count", exp_idx, WORDS);
      t = 0;
      while (busy && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("drain_busy_clears", busy, 0);
      chk("final_flag_low", sram_final_flag, 0);
      chk("drain_gaps", gaps, 0);
      chk("drain_no_extra", exp_idx, WORDS);
      full_rate_mode = 1'b0;
      chk("word5", got_mem[5], 70);
      chk("word7_sat", got_mem[7], 33554431);
      chk("word8_sat", got_mem[8], -33554432);
      chk("word0_acc", got_mem[0], 3);

      // Random backpressure drain, interrupted by reset
      @(posedge clk);
      #1;
      exp_idx = 0;
      rnd_mode = 1'b1;
      drain_start = 1'b1;
      @(posedge clk);
      #1 drain_start = 1'b0;
      t = 0;
      while (exp_idx < 1000 && t < 6000) begin
         @(negedge clk);
         t++;
      end
      chk("rnd_drain_progress", (exp_idx >= 1000) ? 1 : 0, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      rnd_mode = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_we", sram_we, 0);
      chk("midrst_final", sram_final_flag, 0);
      chk("midrst_err_cleared", err_addr, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst_ready", psum_ready, 1);
      chk("after_rst_busy", busy, 0);
      chk("after_rst_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
